// File: rtl/mano_io_ctrl.sv
// Terminal I/O controller for the Mano machine: host FIFO -> INPR/FGI, OUTR/FGO -> tx stream.
// Build option MANO_IO_LOOPBACK_EN routes captured OUTR characters back into the input FIFO.
module mano_io_ctrl #(
  parameter int unsigned FIFO_AW = 2
) (
  input  logic       io_clock,
  input  logic       io_reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic       cpu_fgi,
  input  logic       cpu_fgo,
  input  logic [7:0] cpu_outr,
  output logic [7:0] io_inpr,
  output logic       io_fgiset,
  output logic       io_fgoset
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;

  typedef enum logic [1:0] {I_IDLE, I_DRIVE, I_SET, I_WAIT} i_state_t;
  typedef enum logic [2:0] {O_IDLE, O_CAPT, O_SEND, O_SET, O_WAIT} o_state_t;

  i_state_t i_state, i_next;
  o_state_t o_state, o_next;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]      count, count_next;
  logic               empty, full, push, pop, lb_push, rx_block, tx_load;
  logic [7:0]         push_data;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

`ifdef MANO_IO_LOOPBACK_EN
  // Loopback owns the FIFO write port while capturing; rx is held off for that cycle.
  assign lb_push  = (o_state == O_CAPT) && !full;
  assign rx_block = (o_next == O_CAPT);
  assign tx_load  = 1'b0;
`else
  assign lb_push  = 1'b0;
  assign rx_block = 1'b0;
  assign tx_load  = (o_state == O_CAPT);
`endif

  assign push       = (rx_valid && rx_ready) || lb_push;
  assign push_data  = lb_push ? cpu_outr : rx_data;
  assign pop        = (i_state == I_IDLE) && !empty && !cpu_fgi;
  assign count_next = count + CW'(push) - CW'(pop);

  // Input side: hand one character at a time to INPR, then wait for the CPU to take it.
  always_comb begin
    i_next = i_state;
    case (i_state)
      I_IDLE:  if (pop) i_next = I_DRIVE;
      I_DRIVE: i_next = I_SET;
      I_SET:   i_next = I_WAIT;
      I_WAIT:  if (cpu_fgi) i_next = I_IDLE;
      default: i_next = I_IDLE;
    endcase
  end

  // Output side: each FGO clear captures OUTR, ships it, then raises FGO again.
  always_comb begin
    o_next = o_state;
    case (o_state)
      O_IDLE: if (!cpu_fgo) o_next = O_CAPT;
`ifdef MANO_IO_LOOPBACK_EN
      O_CAPT: if (!full) o_next = O_SET;
`else
      O_CAPT: o_next = O_SEND;
      O_SEND: if (tx_valid && tx_ready) o_next = O_SET;
`endif
      O_SET:   o_next = O_WAIT;
      O_WAIT:  if (cpu_fgo) o_next = O_IDLE;
      default: o_next = O_IDLE;
    endcase
  end

  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      i_state   <= I_IDLE;
      o_state   <= O_SET;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rx_ready  <= 1'b1;
      io_inpr   <= 8'h00;
      io_fgiset <= 1'b0;
      io_fgoset <= 1'b0;
    end else begin
      i_state  <= i_next;
      o_state  <= o_next;
      count    <= count_next;
      rx_ready <= (count_next != CW'(DEPTH)) && !rx_block;
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + FIFO_AW'(1);
        io_inpr <= mem[rd_ptr];
      end
      io_fgiset <= (i_next == I_SET);
      // Lags O_SET by one cycle so the boot pass yields a pulse just after reset release.
      io_fgoset <= (o_state == O_SET);
    end
  end

  always_ff @(posedge io_clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else if (tx_load) begin
      tx_valid <= 1'b1;
      tx_data  <= cpu_outr;
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mano_io_ctrl.sv
// Bench for mano_io_ctrl: directed scenarios plus randomized host/CPU traffic against queue-based expectations.
module tb_mano_io_ctrl;

  logic       io_clock = 1'b0;
  logic       io_reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       cpu_fgi;
  logic       cpu_fgo;
  logic [7:0] cpu_outr;
  logic [7:0] io_inpr;
  logic       io_fgiset;
  logic       io_fgoset;

  mano_io_ctrl #(.FIFO_AW(2)) dut (
    .io_clock (io_clock),
    .io_reset (io_reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .cpu_fgi  (cpu_fgi),
    .cpu_fgo  (cpu_fgo),
    .cpu_outr (cpu_outr),
    .io_inpr  (io_inpr),
    .io_fgiset(io_fgiset),
    .io_fgoset(io_fgoset)
  );

  always #5 io_clock = ~io_clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected characters: host-to-CPU order and CPU-to-host order.
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  int  n_fgiset = 0;
  int  n_fgoset = 0;
  bit  tx_seen = 1'b0;
  logic prev_fgiset = 1'b0;
  logic prev_fgoset = 1'b0;

  always @(posedge io_clock) begin
    if (io_reset) begin
      rxq.delete();
      txq.delete();
    end else begin
      if (rx_valid && rx_ready) rxq.push_back(rx_data);
      if (tx_valid && tx_ready)
        check("tx_char", {24'h0, tx_data}, (txq.size() != 0) ? {24'h0, txq.pop_front()} : 32'h100);
    end
  end

  always @(negedge io_clock) begin
    if (io_fgiset === 1'b1) begin
      n_fgiset++;
      check("fgiset_width", {31'h0, prev_fgiset}, 32'h0);
      check("inpr_order", {24'h0, io_inpr}, (rxq.size() != 0) ? {24'h0, rxq.pop_front()} : 32'h100);
    end
    if (io_fgoset === 1'b1) begin
      n_fgoset++;
      check("fgoset_width", {31'h0, prev_fgoset}, 32'h0);
    end
    if (tx_valid === 1'b1) tx_seen = 1'b1;
    prev_fgiset = io_fgiset;
    prev_fgoset = io_fgoset;
  end

  task automatic tick();
    @(posedge io_clock);
    #1;
  endtask

  // Advance one cycle and retire the host rx request if it transferred on that edge.
  task automatic tick_rx();
    bit xfer;
    xfer = rx_valid && rx_ready;
    tick();
    if (xfer) rx_valid = 1'b0;
  endtask

  task automatic wait_fgiset(input string tag, input int max);
    for (int i = 0; i < max && io_fgiset !== 1'b1; i++) tick_rx();
    check(tag, {31'h0, io_fgiset}, 32'h1);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_inpr"},     {24'h0, io_inpr},   32'h0);
    check({pfx, "_fgiset"},   {31'h0, io_fgiset}, 32'h0);
    check({pfx, "_fgoset"},   {31'h0, io_fgoset}, 32'h0);
    check({pfx, "_tx_valid"}, {31'h0, tx_valid},  32'h0);
    check({pfx, "_tx_data"},  {24'h0, tx_data},   32'h0);
    check({pfx, "_rx_ready"}, {31'h0, rx_ready},  32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int base_i, base_o, fgi_hold, fgo_hold;

    io_reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    cpu_fgi = 1'b0; cpu_fgo = 1'b0; cpu_outr = 8'h00;
    repeat (3) tick();
    check_reset_values("rst");

    // T1: boot pulse on FGO only, nothing transmitted
    base_o = n_fgoset;
    io_reset = 1'b0;
    tick();
    check("t1_boot_fgoset", {31'h0, io_fgoset}, 32'h1);
    tick();
    check("t1_fgoset_end", {31'h0, io_fgoset}, 32'h0);
    repeat (4) tick();
    check("t1_one_pulse", n_fgoset - base_o, 32'h1);
    check("t1_no_tx", {31'h0, tx_seen}, 32'h0);
    cpu_fgo = 1'b1;
    tick();

    // T2: single character latency and single FGI strobe
    base_i = n_fgiset;
    rx_data = 8'h41; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    check("t2_inpr_before", {24'h0, io_inpr}, 32'h0);
    tick();
    check("t2_inpr", {24'h0, io_inpr}, 32'h41);
    check("t2_fgiset_early", {31'h0, io_fgiset}, 32'h0);
    tick();
    check("t2_fgiset", {31'h0, io_fgiset}, 32'h1);
    tick();
    check("t2_fgiset_end", {31'h0, io_fgiset}, 32'h0);
    rx_data = 8'h42; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (4) tick();
    check("t2_no_repulse", n_fgiset - base_i, 32'h1);
    check("t2_inpr_held", {24'h0, io_inpr}, 32'h41);
    cpu_fgi = 1'b1;
    repeat (2) tick();
    cpu_fgi = 1'b0;
    wait_fgiset("t2_second_fgiset", 8);
    check("t2_inpr2", {24'h0, io_inpr}, 32'h42);
    cpu_fgi = 1'b1;
    repeat (3) tick();

    // T3: fill with FGI held, then release per character
    for (int i = 0; i < 4; i++) begin
      check("t3_rx_ready", {31'h0, rx_ready}, 32'h1);
      rx_data = 8'(8'h41 + i); rx_valid = 1'b1;
      tick();
    end
    rx_data = 8'h45;
    check("t3_full", {31'h0, rx_ready}, 32'h0);
    tick();
    check("t3_full_hold", {31'h0, rx_ready}, 32'h0);
    for (int k = 0; k < 5; k++) begin
      cpu_fgi = 1'b0;
      wait_fgiset("t3_fgiset", 8);
      check("t3_inpr_seq", {24'h0, io_inpr}, 32'h41 + k);
      cpu_fgi = 1'b1;
      tick_rx();
      tick_rx();
    end
    check("t3_drained", rxq.size(), 32'h0);

`ifndef MANO_IO_LOOPBACK_EN
    // T4: tx backpressure then FGO strobe
    cpu_outr = 8'h5A; tx_ready = 1'b0; cpu_fgo = 1'b0;
    for (int c = 0; c < 8 && tx_valid !== 1'b1; c++) tick();
    check("t4_tx_valid", {31'h0, tx_valid}, 32'h1);
    check("t4_tx_data", {24'h0, tx_data}, 32'h5A);
    txq.push_back(8'h5A);
    cpu_outr = 8'hFF;
    repeat (3) begin
      tick();
      check("t4_hold_valid", {31'h0, tx_valid}, 32'h1);
      check("t4_hold_data", {24'h0, tx_data}, 32'h5A);
      check("t4_no_fgoset", {31'h0, io_fgoset}, 32'h0);
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("t4_valid_drop", {31'h0, tx_valid}, 32'h0);
    check("t4_fgoset_wait", {31'h0, io_fgoset}, 32'h0);
    tick();
    check("t4_fgoset", {31'h0, io_fgoset}, 32'h1);
    cpu_fgo = 1'b1;
    tick();
    check("t4_fgoset_end", {31'h0, io_fgoset}, 32'h0);
    check("t4_txq_empty", txq.size(), 32'h0);
`endif

    // T5: reset while driving FGI with characters queued and a tx pending
    for (int i = 0; i < 3; i++) begin
      rx_data = 8'(8'h61 + i); rx_valid = 1'b1;
      tick();
    end
    rx_valid = 1'b0;
`ifndef MANO_IO_LOOPBACK_EN
    cpu_outr = 8'h77; cpu_fgo = 1'b0;
    for (int c = 0; c < 8 && tx_valid !== 1'b1; c++) tick();
    check("t5_tx_pending", {31'h0, tx_valid}, 32'h1);
`endif
    cpu_fgi = 1'b0;
    wait_fgiset("t5_in_set", 8);
    io_reset = 1'b1;
    tick();
    check_reset_values("t5_rst");
    tick();
    base_i = n_fgiset;
    base_o = n_fgoset;
    io_reset = 1'b0;
    repeat (6) tick();
    check("t5_no_fgiset", n_fgiset - base_i, 32'h0);
    check("t5_boot_fgoset", n_fgoset - base_o, 32'h1);
    check("t5_rx_ready", {31'h0, rx_ready}, 32'h1);
    check("t5_tx_idle", {31'h0, tx_valid}, 32'h0);
    cpu_fgo = 1'b1;
    repeat (2) tick();

`ifdef MANO_IO_LOOPBACK_EN
    // T6: OUTR loops back to INPR
    cpu_outr = 8'h33; rxq.push_back(8'h33); cpu_fgo = 1'b0; cpu_fgi = 1'b0;
    for (int c = 0; c < 8 && io_fgoset !== 1'b1; c++) tick();
    check("t6_fgoset", {31'h0, io_fgoset}, 32'h1);
    cpu_fgo = 1'b1;
    wait_fgiset("t6_fgiset", 8);
    check("t6_inpr", {24'h0, io_inpr}, 32'h33);
    cpu_fgi = 1'b1;
    repeat (2) tick();
    cpu_fgi = 1'b0;
    tick();
    check("t6_no_tx", {31'h0, tx_seen}, 32'h0);
`endif

    // Random traffic: host pushes, CPU consumes INPR and writes OUTR with random timing
    cpu_fgi = 1'b0; cpu_fgo = 1'b1; fgi_hold = 0; fgo_hold = 1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit drain;
      drain = (cyc >= 450);
`ifndef MANO_IO_LOOPBACK_EN
      if (!rx_valid && !drain && $urandom_range(0, 2) == 0) begin
        rx_data = 8'($urandom); rx_valid = 1'b1;
      end
`endif
      tx_ready = 1'($urandom_range(0, 1));
      if (io_fgiset) begin
        cpu_fgi = 1'b1; fgi_hold = $urandom_range(2, 5);
      end else if (cpu_fgi && fgi_hold > 0) begin
        fgi_hold--;
        if (fgi_hold == 0) cpu_fgi = 1'b0;
      end
      if (io_fgoset) begin
        cpu_fgo = 1'b1; fgo_hold = $urandom_range(1, 4);
      end else if (cpu_fgo && fgo_hold > 0) begin
        fgo_hold--;
        if (fgo_hold == 0 && !drain) begin
          cpu_outr = 8'($urandom);
          cpu_fgo = 1'b0;
`ifdef MANO_IO_LOOPBACK_EN
          rxq.push_back(cpu_outr);
`else
          txq.push_back(cpu_outr);
`endif
        end
      end
      tick_rx();
    end
    check("rand_rxq_empty", rxq.size(), 32'h0);
    check("rand_txq_empty", txq.size(), 32'h0);
    check("rand_rx_done", {31'h0, rx_valid}, 32'h0);
`ifdef MANO_IO_LOOPBACK_EN
    check("rand_no_tx", {31'h0, tx_seen}, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
